// File: rtl/multdiv_arbiter.sv
// Two-requester front end for a single shared multiply/divide unit: round-robin
// grant, held operands, one-cycle start pulse, watchdog-guarded response return.
module multdiv_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 40
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_exception,
    output logic                  rsp_timeout,
    output logic [DATA_WIDTH-1:0] md_operandA,
    output logic [DATA_WIDTH-1:0] md_operandB,
    output logic                  md_ctrl_mult,
    output logic                  md_ctrl_div,
    input  logic [DATA_WIDTH-1:0] md_result,
    input  logic                  md_exception,
    input  logic                  md_resultRDY,
    output logic                  busy
);

    localparam int WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_reg;
    logic                  rr_ptr_reg;
    logic                  owner_reg;
    logic [WDOG_W-1:0]     wdog_reg;
    logic [DATA_WIDTH-1:0] operand_a_reg;
    logic [DATA_WIDTH-1:0] operand_b_reg;
    logic [DATA_WIDTH-1:0] result_reg;
    logic                  exception_reg;
    logic                  timeout_reg;
    logic                  ctrl_mult_reg;
    logic                  ctrl_div_reg;
    logic [1:0]            rsp_valid_reg;

    logic [DATA_WIDTH-1:0] req_a [2];
    logic [DATA_WIDTH-1:0] req_b [2];
    logic [1:0]            grant;
    logic                  accept;
    logic                  accept_idx;
    logic                  rdy_ok;
    logic                  wdog_expired;

    assign req_a[0] = req0_a;
    assign req_b[0] = req0_b;
    assign req_a[1] = req1_a;
    assign req_b[1] = req1_b;

    // A requester wins when it is the only one asking, or when the pointer names it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req_valid[gi] &
                               (~req_valid[1-gi] | (rr_ptr_reg == 1'(gi)));
        end
    endgenerate

    assign req_ready  = (state_reg == S_IDLE) ? grant : 2'b00;
    assign accept     = |req_ready;
    assign accept_idx = req_ready[1];

    // The first WAIT cycle can still see a ready left over from an earlier operation.
    assign rdy_ok       = md_resultRDY && (wdog_reg != '0);
    assign wdog_expired = (wdog_reg == WDOG_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            rr_ptr_reg    <= 1'b0;
            owner_reg     <= 1'b0;
            wdog_reg      <= '0;
            operand_a_reg <= '0;
            operand_b_reg <= '0;
            result_reg    <= '0;
            exception_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            ctrl_mult_reg <= 1'b0;
            ctrl_div_reg  <= 1'b0;
            rsp_valid_reg <= 2'b00;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        owner_reg     <= accept_idx;
                        operand_a_reg <= req_a[accept_idx];
                        operand_b_reg <= req_b[accept_idx];
                        rr_ptr_reg    <= ~accept_idx;
                        ctrl_mult_reg <= ~req_op[accept_idx];
                        ctrl_div_reg  <= req_op[accept_idx];
                        state_reg     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ctrl_mult_reg <= 1'b0;
                    ctrl_div_reg  <= 1'b0;
                    wdog_reg      <= '0;
                    state_reg     <= S_WAIT;
                end
                S_WAIT: begin
                    wdog_reg <= wdog_reg + 1'b1;
                    if (rdy_ok) begin
                        result_reg    <= md_result;
                        exception_reg <= md_exception;
                        timeout_reg   <= 1'b0;
                        rsp_valid_reg <= owner_reg ? 2'b10 : 2'b01;
                        state_reg     <= S_RESP;
                    end else if (wdog_expired) begin
                        result_reg    <= '0;
                        exception_reg <= 1'b1;
                        timeout_reg   <= 1'b1;
                        rsp_valid_reg <= owner_reg ? 2'b10 : 2'b01;
                        state_reg     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid_reg <= 2'b00;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_reg;
    assign rsp_result    = result_reg;
    assign rsp_exception = exception_reg;
    assign rsp_timeout   = timeout_reg;
    assign md_operandA   = operand_a_reg;
    assign md_operandB   = operand_b_reg;
    assign md_ctrl_mult  = ctrl_mult_reg;
    assign md_ctrl_div   = ctrl_div_reg;
    assign busy          = (state_reg != S_IDLE);

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Randomized bench for multdiv_arbiter: a behavioural multdiv with fixed latency,
// a scoreboard computed from requester operands, and round-robin expectations.
module tb_multdiv_arbiter;

    localparam int DW       = 32;
    localparam int TIMEOUT  = 40;
    localparam int MULT_LAT = 17;
    localparam int DIV_LAT  = 33;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_op;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [DW-1:0] rsp_result;
    logic          rsp_exception;
    logic          rsp_timeout;
    logic [DW-1:0] md_operandA, md_operandB;
    logic          md_ctrl_mult, md_ctrl_div;
    logic [DW-1:0] md_result    = '0;
    logic          md_exception = 1'b0;
    logic          md_resultRDY = 1'b0;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    // requester-side pending operations
    logic [1:0]    pend;
    logic          pop [2];
    logic [DW-1:0] pa  [2];
    logic [DW-1:0] pb  [2];
    logic          rr_model;

    // behavioural multdiv controls
    bit            md_dead  = 1'b0;
    bit            md_stale = 1'b0;

    multdiv_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_exception (rsp_exception),
        .rsp_timeout   (rsp_timeout),
        .md_operandA   (md_operandA),
        .md_operandB   (md_operandB),
        .md_ctrl_mult  (md_ctrl_mult),
        .md_ctrl_div   (md_ctrl_div),
        .md_result     (md_result),
        .md_exception  (md_exception),
        .md_resultRDY  (md_resultRDY),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Multdiv stand-in: starts on a ctrl pulse, raises ready for one cycle after its latency.
    int            md_cnt = 0;
    int            md_len = 0;
    bit            dead_l, stale_l;
    logic [DW-1:0] nres;
    logic          nexc;
    always @(negedge clock) begin
        if (!reset_n) begin
            md_cnt       = 0;
            md_resultRDY = 1'b0;
        end else begin
            md_resultRDY = 1'b0;
            if (md_ctrl_mult || md_ctrl_div) begin
                md_len  = md_ctrl_div ? DIV_LAT : MULT_LAT;
                md_cnt  = md_len;
                dead_l  = md_dead;
                stale_l = md_stale;
                if (md_ctrl_div) begin
                    if (md_operandB == '0) begin
                        nres = '0;
                        nexc = 1'b1;
                    end else begin
                        nres = $signed(md_operandA) / $signed(md_operandB);
                        nexc = 1'b0;
                    end
                end else begin
                    nres = md_operandA * md_operandB;
                    nexc = 1'b0;
                end
            end else if (md_cnt > 0) begin
                md_cnt--;
                if (md_cnt == md_len - 1 && stale_l) begin
                    md_resultRDY = 1'b1;
                    md_result    = $urandom;
                    md_exception = 1'b1;
                end else if (md_cnt == 0 && !dead_l) begin
                    md_resultRDY = 1'b1;
                    md_result    = nres;
                    md_exception = nexc;
                end
            end
        end
    end

    task automatic set_op(input int i, input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        pend[i] = 1'b1;
        pop[i]  = op;
        pa[i]   = a;
        pb[i]   = b;
    endtask

    task automatic new_op(input int i);
        logic [DW-1:0] b;
        b = ($urandom_range(0, 5) == 0) ? '0 :
            ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(1, 200));
        if (b == '1) b = 32'd3;
        set_op(i, 1'($urandom_range(0, 1)), DW'($urandom), b);
    endtask

    task automatic drive_reqs();
        req_valid = pend;
        req_op    = {pop[1], pop[0]};
        req0_a    = pa[0];
        req0_b    = pb[0];
        req1_a    = pa[1];
        req1_b    = pb[1];
    endtask

    // One full operation: grant, issue, wait, response with backpressure, release.
    task automatic run_txn(input int hold, input bit dead, input bit stale);
        int            own, cyc, ctrl_cyc, mult_p, div_p, exp_lat;
        bit            got;
        logic [1:0]    onehot;
        logic          eop, eexc, eto;
        logic [DW-1:0] ea, eb, eres;

        drive_reqs();
        md_dead  = dead;
        md_stale = stale;
        #1;
        if (pend[0] && pend[1]) own = int'(rr_model);
        else                    own = pend[1] ? 1 : 0;
        onehot = 2'b01 << own;
        check_eq("req_ready_idle", req_ready, onehot);

        @(negedge clock);
        ea  = pa[own];
        eb  = pb[own];
        eop = pop[own];
        if (dead) begin
            eres = '0; eexc = 1'b1; eto = 1'b1;
        end else if (eop) begin
            eto = 1'b0;
            if (eb == '0) begin
                eres = '0; eexc = 1'b1;
            end else begin
                eres = $signed(ea) / $signed(eb); eexc = 1'b0;
            end
        end else begin
            eres = ea * eb; eexc = 1'b0; eto = 1'b0;
        end
        rr_model  = (own == 0);
        pend[own] = 1'b0;
        req_valid = pend;
        req_op[own] = 1'($urandom_range(0, 1));
        if (own == 0) begin
            req0_a = $urandom; req0_b = $urandom;
        end else begin
            req1_a = $urandom; req1_b = $urandom;
        end

        cyc = 0; ctrl_cyc = -1; mult_p = 0; div_p = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            if (md_ctrl_mult) mult_p++;
            if (md_ctrl_div)  div_p++;
            if ((md_ctrl_mult || md_ctrl_div) && ctrl_cyc < 0) ctrl_cyc = cyc;
            if (rsp_valid != 2'b00) begin
                got = 1'b1;
            end else begin
                check_eq("busy_no_ready", {req_ready, busy}, 3'b001);
                check_eq("operands_held", {md_operandA, md_operandB}, {ea, eb});
                @(negedge clock);
                cyc++;
            end
        end
        exp_lat = (dead ? TIMEOUT : (eop ? DIV_LAT : MULT_LAT)) + 1;
        check_eq("rsp_within_bound", 64'(got), 64'd1);
        check_eq("ctrl_at_issue", 64'(ctrl_cyc), 64'd0);
        check_eq("ctrl_pulses", {32'(mult_p), 32'(div_p)}, eop ? {32'd0, 32'd1} : {32'd1, 32'd0});
        check_eq("latency", 64'(cyc - ctrl_cyc), 64'(exp_lat));
        check_eq("rsp_valid", rsp_valid, onehot);
        check_eq("rsp_result", rsp_result, eres);
        check_eq("rsp_exc_to", {rsp_exception, rsp_timeout}, {eexc, eto});
        check_eq("operands_resp", {md_operandA, md_operandB}, {ea, eb});

        for (int h = 0; h < hold; h++) begin
            rsp_ready = 2'b00;
            rsp_ready[1-own] = 1'($urandom_range(0, 1));
            @(negedge clock);
            check_eq("rsp_hold", {rsp_valid, rsp_result, rsp_exception, rsp_timeout, req_ready},
                     {onehot, eres, eexc, eto, 2'b00});
        end
        rsp_ready = onehot;
        @(negedge clock);
        check_eq("rsp_release", {rsp_valid, busy}, 3'b000);
        rsp_ready = 2'b00;

        $display("txn %0d owner %0d %s a=%0d b=%0d result=%0d exc=%0b timeout=%0b lat=%0d hold=%0d",
                 txn_no, own, eop ? "div" : "mul", $signed(ea), $signed(eb), $signed(rsp_result),
                 rsp_exception, rsp_timeout, cyc - ctrl_cyc, hold);
        txn_no++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        reset_n   = 1'b0;
        pend      = 2'b00;
        pop[0] = 1'b0; pop[1] = 1'b0;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0;
        rr_model  = 1'b0;
        rsp_ready = 2'b00;
        drive_reqs();
        repeat (3) @(negedge clock);
        #1;
        check_eq("reset_outs", {req_ready, rsp_valid, rsp_result, rsp_exception, rsp_timeout, busy}, '0);
        check_eq("reset_md", {md_operandA, md_operandB, md_ctrl_mult, md_ctrl_div}, '0);
        reset_n = 1'b1;
        @(negedge clock);

        // directed cases
        set_op(0, 1'b0, 32'd7, -32'sd6);
        run_txn(0, 1'b0, 1'b0);
        set_op(1, 1'b1, 32'd100, 32'd7);
        run_txn(0, 1'b0, 1'b0);
        set_op(0, 1'b1, 32'd5, 32'd0);
        run_txn(0, 1'b0, 1'b1);
        set_op(0, 1'b0, 32'd11, 32'd13);
        set_op(1, 1'b1, 32'd1000, 32'd9);
        for (int k = 0; k < 4; k++) begin
            run_txn(1, 1'b0, 1'b0);
            for (int i = 0; i < 2; i++) if (!pend[i]) new_op(i);
        end
        pend = 2'b00;
        set_op(1, 1'b0, 32'd3, 32'd4);
        run_txn(10, 1'b0, 1'b0);
        set_op(0, 1'b1, 32'd77, 32'd5);
        run_txn(2, 1'b1, 1'b0);

        // randomized traffic
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 2; i++) if (!pend[i] && $urandom_range(0, 2) != 0) new_op(i);
            if (pend == 2'b00) new_op(int'($urandom_range(0, 1)));
            run_txn(($urandom_range(0, 3) == 0) ? 10 : int'($urandom_range(0, 3)),
                    $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)));
        end

        // reset while waiting on the multdiv
        pend = 2'b00;
        set_op(0, 1'b0, 32'd123, 32'd456);
        md_dead = 1'b0; md_stale = 1'b0;
        drive_reqs();
        @(negedge clock);
        repeat (5) @(negedge clock);
        check_eq("busy_before_reset", 64'(busy), 64'd1);
        reset_n   = 1'b0;
        pend      = 2'b00;
        req_valid = 2'b00;
        #1;
        check_eq("midreset_outs", {req_ready, rsp_valid, rsp_result, rsp_exception, rsp_timeout, busy}, '0);
        check_eq("midreset_md", {md_operandA, md_operandB, md_ctrl_mult, md_ctrl_div}, '0);
        repeat (2) @(negedge clock);
        reset_n  = 1'b1;
        rr_model = 1'b0;
        @(negedge clock);
        set_op(0, 1'b0, 32'd9, 32'd9);
        set_op(1, 1'b1, -32'sd50, 32'd7);
        run_txn(0, 1'b0, 1'b0);
        run_txn(0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
